// File: rtl/ddr2_input_packer_pkg.sv
// Shared constants and types for the DDR2 write-path feeder and the DDR2
// state machine that drains the input FIFO.
package ddr2_input_packer_pkg;

    localparam int          FIFO_SIZE_DEF = 1024;
    localparam int          MARGIN_DEF    = 4;
    localparam int          BURST_LEN     = 8;
    localparam int          WCNT_W        = 10;
    localparam logic [15:0] PAD_WORD_DEF  = 16'h0000;

    // S_LO: no half-word held; S_HI: low half-word waiting for its partner.
    typedef enum logic {
        S_LO = 1'b0,
        S_HI = 1'b1
    } pack_state_t;

    // Pair order on the FIFO bus is {second sample, first sample}.
    function automatic logic [31:0] pack_pair(input logic [15:0] hi, input logic [15:0] lo);
        return {hi, lo};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ddr2_input_packer_if.sv
// Sample-stream, control and FIFO-side signals of the input packer.
// slave  = the packer itself; master = whoever drives the stream and
// observes the FIFO write port (acquisition front end / testbench).
interface ddr2_input_packer_if;
    import ddr2_input_packer_pkg::*;

    logic              enable;
    logic              din_valid;
    logic [15:0]       din;
    logic              flush;
    logic              ovf_clr;
    logic              fifo_full;
    logic [WCNT_W-1:0] fifo_wr_cnt;
    logic              fifo_we;
    logic [31:0]       fifo_din;
    logic              half_held;
    logic              overflow;
    logic [15:0]       drop_count;
    logic [31:0]       words_written;

    modport slave (
        input  enable, din_valid, din, flush, ovf_clr, fifo_full, fifo_wr_cnt,
        output fifo_we, fifo_din, half_held, overflow, drop_count, words_written
    );

    modport master (
        output enable, din_valid, din, flush, ovf_clr, fifo_full, fifo_wr_cnt,
        input  fifo_we, fifo_din, half_held, overflow, drop_count, words_written
    );

endinterface

// File: rtl/ddr2_input_packer.sv
// Packs the 16-bit acquisition stream into 32-bit words for the DDR input
// FIFO, pads an odd trailing half-word on flush or enable drop, refuses
// writes inside the FIFO headroom margin and keeps drop/write statistics.
module ddr2_input_packer
    import ddr2_input_packer_pkg::*;
#(
    parameter int          FIFO_SIZE = FIFO_SIZE_DEF,
    parameter int          MARGIN    = MARGIN_DEF,
    parameter logic [15:0] PAD_WORD  = PAD_WORD_DEF
) (
    input logic                 clk,
    input logic                 reset,
    ddr2_input_packer_if.slave  bus
);

    localparam int WR_LIMIT = FIFO_SIZE - MARGIN;

    pack_state_t state_q, state_d;
    logic [15:0] lo_q, lo_d;
    logic        fifo_we_q;
    logic [31:0] fifo_din_q;
    logic        overflow_q;
    logic [15:0] drop_count_q;
    logic [31:0] words_written_q;

    logic        take;
    logic        admit;
    logic        emit;
    logic [31:0] emit_word;

    assign take  = bus.enable && bus.din_valid;
    // Admission is judged on the FIFO status seen in the completing cycle.
    assign admit = !bus.fifo_full && (32'(bus.fifo_wr_cnt) < 32'(WR_LIMIT));

    // Next-state and word assembly; din is consumed before flush is applied.
    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        emit      = 1'b0;
        emit_word = '0;
        case (state_q)
            S_LO: begin
                if (take) begin
                    if (bus.flush) begin
                        emit      = 1'b1;
                        emit_word = pack_pair(PAD_WORD, bus.din);
                    end else begin
                        lo_d    = bus.din;
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                if (take) begin
                    emit      = 1'b1;
                    emit_word = pack_pair(bus.din, lo_q);
                    state_d   = S_LO;
                end else if (bus.flush || !bus.enable) begin
                    // Enable low is only ever seen once here, since we leave S_HI.
                    emit      = 1'b1;
                    emit_word = pack_pair(PAD_WORD, lo_q);
                    state_d   = S_LO;
                end
            end
            default: state_d = S_LO;
        endcase
    end

    // State, registered FIFO write port and statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_LO;
            lo_q            <= '0;
            fifo_we_q       <= 1'b0;
            fifo_din_q      <= '0;
            overflow_q      <= 1'b0;
            drop_count_q    <= '0;
            words_written_q <= '0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            fifo_we_q <= emit && admit;
            if (emit && admit) begin
                fifo_din_q      <= emit_word;
                words_written_q <= words_written_q + 32'd1;
            end
            // A refused word in the same cycle as a clear leaves one drop on record.
            if (emit && !admit) begin
                overflow_q   <= 1'b1;
                drop_count_q <= bus.ovf_clr ? 16'd1 : sat_inc16(drop_count_q);
            end else if (bus.ovf_clr) begin
                overflow_q   <= 1'b0;
                drop_count_q <= '0;
            end
        end
    end

    assign bus.fifo_we       = fifo_we_q;
    assign bus.fifo_din      = fifo_din_q;
    assign bus.half_held     = (state_q == S_HI);
    assign bus.overflow      = overflow_q;
    assign bus.drop_count    = drop_count_q;
    assign bus.words_written = words_written_q;

endmodule
